// File: rtl/ece453_seg7_scan.sv
// Multiplexed 4-digit common-anode 7-segment scanner with dead-time and frame-synchronous value commit.
// Optional leading-zero suppression: define SEG7_LZ_SUPPRESS_EN.
module ece453_seg7_scan #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned DEAD_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        value_load,
    input  logic        blank,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_done,
    output logic        pending
);

    localparam int unsigned CMAX = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST   = CW'(SCAN_DIV - 1);

    typedef enum logic {ST_DEAD, ST_ON} state_t;

    state_t      state_q, state_d;
    logic [1:0]  digit_q, digit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] act_val_q, act_val_d;
    logic [3:0]  act_dp_q, act_dp_d;
    logic [3:0]  act_en_q, act_en_d;
    logic [23:0] buf_q, buf_d;
    logic        pend_q, pend_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [3:0]  an_q, an_d;
    logic        fd_q, fd_d;

    logic        boundary;
    logic        lit;
    logic        lz_dark;
    logic [3:0]  nib;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        cnt_d     = cnt_q;
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        act_en_d  = act_en_q;
        buf_d     = buf_q;
        pend_d    = pend_q;
        fd_d      = 1'b0;
        boundary  = 1'b0;
        lz_dark   = 1'b0;
        lit       = 1'b0;
        nib       = '0;

        if (state_q == ST_DEAD) begin
            if (cnt_q == DEAD_LAST) begin
                state_d = ST_ON;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            if (cnt_q == ON_LAST) begin
                state_d  = ST_DEAD;
                cnt_d    = '0;
                digit_d  = digit_q + 2'd1;
                boundary = (digit_q == 2'd3);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // A load coinciding with the boundary bypasses the buffer and wins over older pending data.
        if (boundary) begin
            fd_d   = 1'b1;
            pend_d = 1'b0;
            if (value_load) begin
                {act_val_d, act_dp_d, act_en_d} = {value, dp_in, digit_en};
                buf_d = {value, dp_in, digit_en};
            end else if (pend_q) begin
                {act_val_d, act_dp_d, act_en_d} = buf_q;
            end
        end else if (value_load) begin
            buf_d  = {value, dp_in, digit_en};
            pend_d = 1'b1;
        end

`ifdef SEG7_LZ_SUPPRESS_EN
        case (digit_d)
            2'd1:    lz_dark = (act_val_d[15:4] == '0);
            2'd2:    lz_dark = (act_val_d[15:8] == '0);
            2'd3:    lz_dark = (act_val_d[15:12] == '0);
            default: lz_dark = 1'b0;
        endcase
`endif

        nib = act_val_d[{digit_d, 2'b00} +: 4];
        lit = (state_d == ST_ON) && act_en_d[digit_d] && !blank && !lz_dark;

        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (lit) begin
            an_d[digit_d] = 1'b0;
            seg_d = hex7(nib);
            dp_d  = ~act_dp_d[digit_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_DEAD;
            digit_q   <= '0;
            cnt_q     <= '0;
            act_val_q <= '0;
            act_dp_q  <= '0;
            act_en_q  <= '0;
            buf_q     <= '0;
            pend_q    <= 1'b0;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
            an_q      <= 4'hF;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            digit_q   <= digit_d;
            cnt_q     <= cnt_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            act_en_q  <= act_en_d;
            buf_q     <= buf_d;
            pend_q    <= pend_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
        end
    end

    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign an_n       = an_q;
    assign frame_done = fd_q;
    assign pending    = pend_q;

endmodule

// File: tb/tb_ece453_seg7_scan.sv
// Scoreboard bench for ece453_seg7_scan: frame-position reference model feeds an expectation queue.
module tb_ece453_seg7_scan;

    localparam int SD    = 4;
    localparam int DC    = 2;
    localparam int SLOT  = SD + DC;
    localparam int FRAME = 4 * SLOT;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        value_load = 1'b0;
    logic        blank = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;
    logic        pending;

    ece453_seg7_scan #(.SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .value_load(value_load), .blank(blank), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
        .frame_done(frame_done), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] v;
        int          n;
        int          tst;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int tst      = 0;

    // Reference model state (only the driver process writes these)
    int          n;
    logic [15:0] m_val;
    logic [3:0]  m_dp, m_en;
    logic [23:0] m_buf;
    logic        m_pend;

    function automatic bit lz(input logic [15:0] v, input int k);
`ifdef SEG7_LZ_SUPPRESS_EN
        return (k > 0) && ((v >> (4 * k)) == 16'h0);
`else
        return (k < 0) && (v == 16'h0);
`endif
    endfunction

    task automatic compare(input string name, input int idx, input logic [14:0] got, input logic [14:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got an_n=%h seg_n=%h dp_n=%b frame_done=%b pending=%b, expected an_n=%h seg_n=%h dp_n=%b frame_done=%b pending=%b",
                     name, idx, got[14:11], got[10:4], got[3], got[2], got[1],
                     exp[14:11], exp[10:4], exp[3], exp[2], exp[1]);
        end
    endtask

    task automatic model_reset();
        n = 0; m_val = '0; m_dp = '0; m_en = '0; m_buf = '0; m_pend = 1'b0;
    endtask

    // Call at a negedge: drives inputs, predicts the outputs after the next posedge, waits for the next negedge.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en, input logic bl);
        int pos, d;
        bit on, litv;
        logic [3:0]  an;
        logic [6:0]  sg;
        logic        dpo;
        exp_t e;
        value = v; dp_in = dp; digit_en = en; value_load = ld; blank = bl;
        n++;
        pos = n % FRAME;
        if (pos == 0) begin
            if (ld) {m_val, m_dp, m_en} = {v, dp, en};
            else if (m_pend) {m_val, m_dp, m_en} = m_buf;
            m_pend = 1'b0;
        end else if (ld) begin
            m_buf = {v, dp, en};
            m_pend = 1'b1;
        end
        d    = pos / SLOT;
        on   = (pos % SLOT) >= DC;
        litv = on && m_en[d] && !bl && !lz(m_val, d);
        an = 4'hF; sg = 7'h7F; dpo = 1'b1;
        if (litv) begin
            an  = ~(4'b0001 << d);
            sg  = HEX[(m_val >> (4 * d)) & 16'hF];
            dpo = ~m_dp[d];
        end
        e.v = {an, sg, dpo, (pos == 0), m_pend, 1'b0};
        e.n = n;
        e.tst = tst;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    endtask

    // Advance so that the next step lands on frame position p.
    task automatic goto_pos(input int p);
        for (int i = 0; i < FRAME && ((n + 1) % FRAME) != p; i++) idle(1);
    endtask

    // Monitor: every cycle the DUT presents a registered output, check it against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                compare($sformatf("test%0d edge", e.tst), e.n, {an_n, seg_n, dp_n, frame_done, pending, 1'b0}, e.v);
            end
        end
    end

    initial begin
        int waits;
        logic [15:0] rv;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        compare("reset_state", 0, {an_n, seg_n, dp_n, frame_done, pending, 1'b0}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // 1: free-running first frame, active value still cleared
        tst = 1;
        idle(FRAME + 2);

        // 2: mid-frame load persists only as pending until the boundary
        tst = 2;
        goto_pos(10);
        step(1'b1, 16'hA81F, 4'b0100, 4'hF, 1'b0);
        goto_pos(0);
        idle(FRAME);

        // 3: two loads in one frame, last wins
        tst = 3;
        goto_pos(3);
        step(1'b1, 16'h1111, 4'h0, 4'hF, 1'b0);
        idle(5);
        step(1'b1, 16'h2222, 4'h0, 4'hF, 1'b0);
        goto_pos(0);
        idle(FRAME);

        // 4: load on the boundary edge commits directly, with an older value pending
        tst = 4;
        goto_pos(7);
        step(1'b1, 16'h9999, 4'hF, 4'hF, 1'b0);
        goto_pos(0);
        step(1'b1, 16'h0005, 4'h0, 4'hF, 1'b0);
        idle(FRAME);

        // 5: blank during ON(d2), then sparse digit enable
        tst = 5;
        goto_pos(2 * SLOT + DC);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b1);
        step(1'b1, 16'h4321, 4'b1111, 4'b0101, 1'b0);
        goto_pos(0);
        idle(FRAME + 1);

        // 6: leading zeros
        tst = 6;
        step(1'b1, 16'h0070, 4'h0, 4'hF, 1'b0);
        goto_pos(0);
        idle(FRAME + 1);
        step(1'b1, 16'h0000, 4'hF, 4'hF, 1'b0);
        goto_pos(0);
        idle(FRAME + 1);

        // 7: randomized loads and blanking
        tst = 7;
        for (int i = 0; i < 600; i++) begin
            rv = 16'($urandom) >> (4 * $urandom_range(0, 3));
            step($urandom_range(0, 7) == 0, rv, 4'($urandom), 4'($urandom), $urandom_range(0, 9) == 0);
        end

        // 8: asynchronous reset mid-frame, then restart from DEAD(d0)
        tst = 8;
        goto_pos(2 * SLOT + DC + 1);
        step(1'b1, 16'hBEEF, 4'h5, 4'hF, 1'b0);
        #2 reset = 1'b1;
        #1;
        compare("async_reset", n, {an_n, seg_n, dp_n, frame_done, pending, 1'b0}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle(5);
        step(1'b1, 16'hC0DE, 4'b1001, 4'hF, 1'b0);
        idle(2 * FRAME);

        waits = 0;
        while (q.size() > 0 && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d queued expectations, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
